// File: rtl/dll_pkg.sv
// dll_pkg: shared types for the DLL lock controller.
// FSM states, vote decisions, step directions and mode codes.
package dll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_TRACK_SETTLE,
    ST_TRACK_SAMPLE
  } state_t;

  typedef enum logic [1:0] {
    DEC_EARLY,
    DEC_LATE,
    DEC_TIE
  } dec_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } dir_t;

  localparam logic MODE_BB  = 1'b0;
  localparam logic MODE_SAR = 1'b1;

  // Majority vote: more than half early -> EARLY.
  function automatic dec_t vote_decide(
    input int unsigned votes,
    input int unsigned half
  );
    dec_t d;
    if (votes > half)
      d = DEC_EARLY;
    else if (votes < half)
      d = DEC_LATE;
    else
      d = DEC_TIE;
    return d;
  endfunction

endpackage

// File: rtl/dll_sync.sv
// dll_sync: flop-chain synchroniser for async inputs.
// Resets to 0; output is the last stage of the chain.
module dll_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the async input through the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_chain <= '0;
    else
      r_chain <= (r_chain << 1) | STAGES'(i_d);
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/dll_lock_ctrl.sv
// dll_lock_ctrl: DLL tap-code controller.
// SAR or bang-bang acquisition, voted tracking, lock detect.
module dll_lock_ctrl
  import dll_pkg::*;
#(
  parameter int CODE_W        = 6,
  parameter int FILT_LOG2     = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_WINDOWS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              pd_early,
  output logic [CODE_W-1:0] delay_code,
  output logic              acq_done,
  output logic              locked,
  output logic              lock_lost,
  output logic              sat
);

  localparam int NSAMP   = 1 << FILT_LOG2;
  localparam int HALF    = NSAMP / 2;
  localparam int CNT_MAX =
    (SETTLE_CYCLES > NSAMP) ? SETTLE_CYCLES : NSAMP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int VOTE_W  = FILT_LOG2 + 1;
  localparam int BIT_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int LCK_W   = $clog2(LOCK_WINDOWS + 1);

  localparam logic [CODE_W-1:0] MID  = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-1:0] MAXC = {CODE_W{1'b1}};
  localparam logic [LCK_W-1:0]  LMAX = LCK_W'(LOCK_WINDOWS);
  localparam logic [CNT_W-1:0]  SETL = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SMPL = CNT_W'(NSAMP - 1);

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [VOTE_W-1:0]  r_vote, w_vote_nx, w_vote_sum;
  logic [CODE_W-1:0]  r_code, w_code_nx;
  logic [BIT_W-1:0]   r_bit, w_bit_nx, w_bit_dn;
  logic [LCK_W-1:0]   r_lock_cnt, w_lock_cnt_nx;
  dir_t               r_dir, w_dir_nx, w_move;
  logic               r_acq, w_acq_nx;
  logic               r_locked, w_locked_nx;
  logic               r_lost, w_lost_nx;
  logic               r_sat, w_sat_nx;
  logic               w_pe_s;
  dec_t               w_dec;

  dll_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pd_early),
    .o_q (w_pe_s)
  );

  assign w_vote_sum = r_vote + VOTE_W'(w_pe_s);
  assign w_dec      = vote_decide(32'(w_vote_sum), HALF);
  assign w_bit_dn   = r_bit - BIT_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_vote     <= '0;
      r_code     <= MID;
      r_bit      <= BIT_W'(CODE_W - 1);
      r_lock_cnt <= '0;
      r_dir      <= DIR_NONE;
      r_acq      <= 1'b0;
      r_locked   <= 1'b0;
      r_lost     <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_vote     <= w_vote_nx;
      r_code     <= w_code_nx;
      r_bit      <= w_bit_nx;
      r_lock_cnt <= w_lock_cnt_nx;
      r_dir      <= w_dir_nx;
      r_acq      <= w_acq_nx;
      r_locked   <= w_locked_nx;
      r_lost     <= w_lost_nx;
      r_sat      <= w_sat_nx;
    end
  end

  // Next state: settle/sample sequencing, SAR, tracking, lock.
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_vote_nx     = r_vote;
    w_code_nx     = r_code;
    w_bit_nx      = r_bit;
    w_lock_cnt_nx = r_lock_cnt;
    w_dir_nx      = r_dir;
    w_acq_nx      = r_acq;
    w_locked_nx   = r_locked;
    w_lost_nx     = 1'b0;
    w_sat_nx      = 1'b0;
    w_move        = DIR_NONE;

    if (r_state != ST_IDLE && !en) begin
      // Disable: code holds, everything else drops quietly.
      w_state_nx    = ST_IDLE;
      w_cnt_nx      = '0;
      w_vote_nx     = '0;
      w_lock_cnt_nx = '0;
      w_dir_nx      = DIR_NONE;
      w_acq_nx      = 1'b0;
      w_locked_nx   = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (en) begin
            w_code_nx     = MID;
            w_bit_nx      = BIT_W'(CODE_W - 1);
            w_cnt_nx      = '0;
            w_vote_nx     = '0;
            w_lock_cnt_nx = '0;
            w_dir_nx      = DIR_NONE;
            if (mode == MODE_SAR) begin
              w_state_nx = ST_SETTLE;
            end else begin
              w_state_nx = ST_TRACK_SETTLE;
              w_acq_nx   = 1'b1;
            end
          end
        end

        ST_SETTLE, ST_TRACK_SETTLE: begin
          if (r_cnt == SETL) begin
            w_cnt_nx   = '0;
            w_state_nx = (r_state == ST_SETTLE) ?
                         ST_SAMPLE : ST_TRACK_SAMPLE;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end

        ST_SAMPLE: begin
          if (r_cnt == SMPL) begin
            w_cnt_nx  = '0;
            w_vote_nx = '0;
            if (w_dec == DEC_LATE)
              w_code_nx[r_bit] = 1'b0;
            if (r_bit != '0) begin
              w_code_nx[w_bit_dn] = 1'b1;
              w_bit_nx   = w_bit_dn;
              w_state_nx = ST_SETTLE;
            end else begin
              w_acq_nx      = 1'b1;
              w_state_nx    = ST_TRACK_SETTLE;
              w_dir_nx      = DIR_NONE;
              w_lock_cnt_nx = '0;
            end
          end else begin
            w_cnt_nx  = r_cnt + CNT_W'(1);
            w_vote_nx = w_vote_sum;
          end
        end

        ST_TRACK_SAMPLE: begin
          if (r_cnt == SMPL) begin
            w_cnt_nx   = '0;
            w_vote_nx  = '0;
            w_state_nx = ST_TRACK_SETTLE;
            unique case (w_dec)
              DEC_EARLY: begin
                w_move = DIR_UP;
                if (r_code == MAXC)
                  w_sat_nx = 1'b1;
                else
                  w_code_nx = r_code + CODE_W'(1);
              end
              DEC_LATE: begin
                w_move = DIR_DN;
                if (r_code == '0)
                  w_sat_nx = 1'b1;
                else
                  w_code_nx = r_code - CODE_W'(1);
              end
              default: w_move = DIR_NONE;
            endcase
            // Blocked steps still count as a move in their direction.
            if (w_move != DIR_NONE && w_move == r_dir) begin
              w_lock_cnt_nx = '0;
              if (r_locked) begin
                w_locked_nx = 1'b0;
                w_lost_nx   = 1'b1;
              end
            end else begin
              if (r_lock_cnt != LMAX)
                w_lock_cnt_nx = r_lock_cnt + LCK_W'(1);
              if (w_lock_cnt_nx == LMAX)
                w_locked_nx = 1'b1;
            end
            if (w_move != DIR_NONE)
              w_dir_nx = w_move;
          end else begin
            w_cnt_nx  = r_cnt + CNT_W'(1);
            w_vote_nx = w_vote_sum;
          end
        end

        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  assign delay_code = r_code;
  assign acq_done   = r_acq;
  assign locked     = r_locked;
  assign lock_lost  = r_lost;
  assign sat        = r_sat;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// tb_dll_lock_ctrl: table-driven bench for dll_lock_ctrl.
// Phase-detector model: pd_early = (code < tgt); tgt<0 toggles.
module tb_dll_lock_ctrl;
  import dll_pkg::*;

  typedef struct {
    int         tgt;
    logic [5:0] code;
    logic       acq;
    logic       lk;
    logic       lost;
    logic       sat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       pd_early = 1'b0;
  logic [5:0] delay_code;
  logic       acq_done, locked, lock_lost, sat;

  int   tgt = 37;
  int   checks = 0;
  int   failures = 0;
  vec_t vt[$];

  dll_lock_ctrl #(
    .CODE_W(6),
    .FILT_LOG2(3),
    .SETTLE_CYCLES(4),
    .SYNC_STAGES(2),
    .LOCK_WINDOWS(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .pd_early   (pd_early),
    .delay_code (delay_code),
    .acq_done   (acq_done),
    .locked     (locked),
    .lock_lost  (lock_lost),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tgt < 0)
      pd_early = ~pd_early;
    else
      pd_early = (int'(delay_code) < tgt);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int t, input int c, input logic a,
                     input logic l, input logic lo, input logic s);
    vec_t r;
    r.tgt  = t;
    r.code = 6'(c);
    r.acq  = a;
    r.lk   = l;
    r.lost = lo;
    r.sat  = s;
    vt.push_back(r);
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic start(input logic m, input int t);
    tgt = t;
    @(negedge clk);
    mode = m;
    en   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tgt = vt[i].tgt;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_lost_clr", i), int'(lock_lost), 0);
      chk($sformatf("v%0d_sat_clr", i), int'(sat), 0);
      repeat (11) @(posedge clk);
      #1;
      chk($sformatf("v%0d_code", i), int'(delay_code),
          int'(vt[i].code));
      chk($sformatf("v%0d_acq", i), int'(acq_done), int'(vt[i].acq));
      chk($sformatf("v%0d_locked", i), int'(locked), int'(vt[i].lk));
      chk($sformatf("v%0d_lost", i), int'(lock_lost),
          int'(vt[i].lost));
      chk($sformatf("v%0d_sat", i), int'(sat), int'(vt[i].sat));
    end
  endtask

  initial begin
    // SAR to 37, track, then lose lock and relock at 30 (0..22).
    add(37, 48, 0, 0, 0, 0);
    add(37, 40, 0, 0, 0, 0);
    add(37, 36, 0, 0, 0, 0);
    add(37, 38, 0, 0, 0, 0);
    add(37, 37, 0, 0, 0, 0);
    add(37, 36, 1, 0, 0, 0);
    add(37, 37, 1, 0, 0, 0);
    add(37, 36, 1, 0, 0, 0);
    add(37, 37, 1, 0, 0, 0);
    add(37, 36, 1, 1, 0, 0);
    add(37, 37, 1, 1, 0, 0);
    add(30, 36, 1, 1, 0, 0);
    add(30, 35, 1, 0, 1, 0);
    for (int c = 34; c >= 29; c--)
      add(30, c, 1, 0, 0, 0);
    add(30, 30, 1, 0, 0, 0);
    add(30, 29, 1, 0, 0, 0);
    add(30, 30, 1, 0, 0, 0);
    add(30, 29, 1, 1, 0, 0);
    // Bang-bang climb to 40 and dither (23..34).
    for (int k = 1; k <= 8; k++)
      add(40, 32 + k, 1, 0, 0, 0);
    add(40, 39, 1, 0, 0, 0);
    add(40, 40, 1, 0, 0, 0);
    add(40, 39, 1, 0, 0, 0);
    add(40, 40, 1, 1, 0, 0);
    // Saturation at the top code (35..67).
    for (int k = 1; k <= 31; k++)
      add(64, 32 + k, 1, 0, 0, 0);
    add(64, 63, 1, 0, 0, 1);
    add(64, 63, 1, 0, 0, 1);
    // Ties from a toggling detector (68..72).
    for (int k = 1; k <= 3; k++)
      add(-1, 32, 1, 0, 0, 0);
    add(-1, 32, 1, 1, 0, 0);
    add(-1, 32, 1, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_code", int'(delay_code), 32);
    chk("rst_acq", int'(acq_done), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_lost", int'(lock_lost), 0);
    chk("rst_sat", int'(sat), 0);
    rst = 1'b0;

    start(MODE_SAR, 37);
    run(0, 22);

    // Async reset in the middle of a sample window.
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_code", int'(delay_code), 32);
    chk("arst_acq", int'(acq_done), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_lost", int'(lock_lost), 0);
    chk("arst_sat", int'(sat), 0);
    en = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_idle", int'(dut.r_state), int'(ST_IDLE));
    repeat (3) @(posedge clk);
    #1;
    chk("arst_code_hold", int'(delay_code), 32);

    start(MODE_BB, 40);
    run(23, 34);

    // Disable while locked: code holds, flags drop, no pulse.
    repeat (3) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("dis_code", int'(delay_code), 40);
    chk("dis_locked", int'(locked), 0);
    chk("dis_acq", int'(acq_done), 0);
    chk("dis_lost", int'(lock_lost), 0);
    chk("dis_idle", int'(dut.r_state), int'(ST_IDLE));
    repeat (5) @(posedge clk);
    #1;
    chk("dis_code_hold", int'(delay_code), 40);
    chk("dis_lost_hold", int'(lock_lost), 0);

    do_reset();
    start(MODE_BB, 64);
    run(35, 67);

    do_reset();
    start(MODE_BB, -1);
    run(68, 72);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("tie_dis_code", int'(delay_code), 32);
    chk("tie_dis_locked", int'(locked), 0);
    chk("tie_dis_lost", int'(lock_lost), 0);
    chk("tie_dis_idle", int'(dut.r_state), int'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
